// File: rtl/boot_loader_ctrl.sv
// Boot loader: assembles UART bytes into 16-bit words, writes them to instruction
// memory and holds the CPU in reset until a length/XOR-checked frame completes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for boot_en, CPU released
// S_LEN  | waiting for the word-count header byte (no timeout)
// S_HI   | waiting for the high byte of the next word
// S_LO   | waiting for the low byte; accept issues the memory write
// S_CHK  | waiting for the XOR checksum byte
// S_DONE | frame good, CPU released, wait for boot_en to drop
// S_ERR  | frame bad or timed out, CPU held, wait for boot_en to drop
module boot_loader_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_en,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      len_q;
  logic [7:0]      idx_q;
  logic [7:0]      hi_q;
  logic [7:0]      acc_q;
  logic [TO_W-1:0] to_cnt;
  logic            consumed_q;
  logic            accept;
  logic            in_frame;
  logic            timed;
  logic            to_hit;

  always_comb begin
    in_frame   = (state == S_LEN) || (state == S_HI) || (state == S_LO) || (state == S_CHK);
    timed      = (state == S_HI) || (state == S_LO) || (state == S_CHK);
    // consumed_q blocks re-accepting a byte whose rx_rdy has not yet dropped
    accept     = in_frame && boot_en && rx_rdy && !consumed_q;
    to_hit     = timed && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    clr_rx_rdy = accept;
    cpu_hold   = in_frame || (state == S_ERR);
    done       = (state == S_DONE);
    err        = (state == S_ERR);
    state_nxt  = state;

    case (state)
      S_IDLE: begin
        if (boot_en) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (!boot_en)    state_nxt = S_IDLE;
        else if (accept) state_nxt = (rx_data == 8'd0) ? S_ERR : S_HI;
      end
      S_HI: begin
        if (!boot_en)    state_nxt = S_IDLE;
        else if (accept) state_nxt = S_LO;
        else if (to_hit) state_nxt = S_ERR;
      end
      S_LO: begin
        if (!boot_en)    state_nxt = S_IDLE;
        else if (accept) state_nxt = ((idx_q + 8'd1) == len_q) ? S_CHK : S_HI;
        else if (to_hit) state_nxt = S_ERR;
      end
      S_CHK: begin
        if (!boot_en)    state_nxt = S_IDLE;
        else if (accept) state_nxt = (rx_data == acc_q) ? S_DONE : S_ERR;
        else if (to_hit) state_nxt = S_ERR;
      end
      S_DONE: begin
        if (!boot_en) state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (!boot_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we         <= 1'b0;
      waddr      <= ADDR_W'(BASE_ADDR);
      wdata      <= 16'd0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      hi_q       <= 8'd0;
      acc_q      <= 8'd0;
      to_cnt     <= '0;
      consumed_q <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= 1'b0;

      if (!rx_rdy)     consumed_q <= 1'b0;
      else if (accept) consumed_q <= 1'b1;

      if (accept || !timed) to_cnt <= '0;
      else if (!to_hit)     to_cnt <= to_cnt + 1'b1;

      if (state == S_IDLE) begin
        idx_q <= 8'd0;
        acc_q <= 8'd0;
      end

      if (accept) begin
        case (state)
          S_LEN: len_q <= rx_data;
          S_HI: begin
            hi_q  <= rx_data;
            acc_q <= acc_q ^ rx_data;
          end
          S_LO: begin
            acc_q <= acc_q ^ rx_data;
            wdata <= {hi_q, rx_data};
            waddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
            we    <= 1'b1;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Consumes the byte stream from the boot UART receiver (the host side transmits into BOOT_RX) and assembles it into 16-bit instruction words.
- Writes those words sequentially into instruction memory.
- Holds the CPU in reset while a load is in progress.
- Validates the frame with a length header, an XOR checksum and an inter-byte timeout, then reports done or err.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- BASE_ADDR, 0, address of the first word written.
- TIMEOUT_CYC, 65536, max idle clocks between bytes inside a frame before abort (one byte at 115200 baud / 50 MHz is about 4340 clocks).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- boot_en  in  1  load enable from SW[0], level-sensitive.
- rx_rdy  in  1  UART receiver has a byte; stays high until cleared.
- rx_data  in  8  received byte, valid while rx_rdy=1.
- clr_rx_rdy  out  1  one-cycle pulse that consumes the current byte.
- we  out  1  instruction memory write strobe.
- waddr  out  ADDR_W  instruction memory word address.
- wdata  out  16  instruction word.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  load completed and checksum matched.
- err  out  1  load failed.

Behaviour:
- Frame format: LEN byte N (1..255 words), then 2N payload bytes (high byte first per word), then CHK byte = XOR of all 2N payload bytes. Total bytes = 2N+2 (N=16 gives 34 bytes).
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - we, clr_rx_rdy, cpu_hold, done and err all 0.
  - waddr=BASE_ADDR, wdata=0.
  - Word index, XOR accumulator and timeout counter cleared.
  - Reset overrides everything, including mid-load.
- Byte acceptance:
  - Occurs only in LEN, HI, LO and CHK, and only when rx_rdy=1.
  - clr_rx_rdy is combinational, high in exactly that cycle; rx_data is captured at the same edge.
  - Each byte is consumed exactly once even if rx_rdy stays high for several cycles.
  - rx_rdy is ignored in IDLE, DONE and ERR, and clr_rx_rdy stays 0 there.
- IDLE:
  - cpu_hold=0.
  - Moves to LEN on the edge where boot_en=1.
  - cpu_hold rises on that edge.
  - Index and XOR accumulator are cleared.
- LEN:
  - Waits for a byte; no timeout applies in this state.
  - Byte 0 -> ERR.
  - Byte N>0 -> latch N, go to HI.
- HI: on a byte, latch hi=rx_data, acc^=rx_data, go to LO.
- LO: on a byte:
  - acc^=rx_data.
  - Registered outputs on the next cycle: wdata={hi,rx_data}, waddr=BASE_ADDR+index, we=1 for exactly one cycle.
  - index++.
  - If the new index equals N -> CHK, else -> HI.
  - waddr increment wraps modulo 2^ADDR_W.
- CHK: on a byte, rx_data==acc -> DONE, otherwise -> ERR.
- DONE:
  - done=1, cpu_hold=0.
  - Stays in DONE while boot_en=1.
  - boot_en=0 -> IDLE with done cleared.
  - A new load needs a fresh boot_en rising edge.
- ERR:
  - err=1, cpu_hold=1 (CPU stays held).
  - boot_en=0 -> IDLE with err cleared and cpu_hold=0.
- Timeout:
  - In HI, LO and CHK the counter increments every cycle with no byte accepted, and clears on every accept.
  - Reaching TIMEOUT_CYC -> ERR.
  - If a byte arrives in the same cycle the count would reach TIMEOUT_CYC, the byte wins.
- boot_en=0 in LEN, HI, LO or CHK:
  - Abort to IDLE next edge; cpu_hold=0.
  - No further writes occur, except a we already registered from the preceding LO accept, which still completes.
  - A byte presented in that same cycle is not consumed.
- Words already written before an ERR are not rolled back.

Test Plan:
- Good 34-byte frame (N=0x10, bytes 0x00..0x1F, CHK=0x00) with boot_en=1 -> 16 we pulses.
  - waddr 0..15, wdata 0x0001, 0x0203, ... 0x1E1F.
  - done=1, err=0, and cpu_hold falls on the edge after the CHK byte.
- Same frame with CHK=0x5A -> 16 writes, then err=1, done=0, cpu_hold stays 1.
  - Drop boot_en -> IDLE, err=0, cpu_hold=0.
- LEN=0x00 -> err=1 with no we pulses.
  - Feed more bytes -> clr_rx_rdy stays 0.
- Hold rx_rdy high 5 cycles per byte (receiver slow to clear) -> exactly one clr_rx_rdy per byte, and the write count still equals N.
- N=2, send 3 payload bytes, then silence for TIMEOUT_CYC clocks -> one write (0xAABB), then err=1.
  - With a byte arriving at TIMEOUT_CYC-1 idle clocks -> no error.
- Mid-frame boot_en=0 after word 5 -> IDLE next edge, cpu_hold=0, no further writes.
  - Re-assert boot_en and send a full frame -> writes restart at BASE_ADDR and done=1.
  - Assert rst mid-frame -> all outputs 0 at the next edge.
